// File: rtl/uncached_req_ctrl.sv
// Uncached/write-through request feeder: packs MEM-stage loads and stores into FIFO lines,
// posts stores, blocks loads until their response line returns, and tracks in-flight entries.
// Optional response label check enabled by defining UNCACHED_LABEL_CHECK_EN.
module uncached_req_ctrl #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned PHYS_WIDTH   = 32,
  parameter int unsigned MAX_INFLIGHT = 10,
  parameter int unsigned CNT_WIDTH    = 4,
  localparam int unsigned BE_W        = DATA_WIDTH / 8,
  localparam int unsigned OFF_W       = $clog2(BE_W),
  localparam int unsigned LABEL_W     = PHYS_WIDTH - OFF_W,
  localparam int unsigned LINE_W      = 1 + BE_W + LABEL_W + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [BE_W-1:0]       req_be,
  input  logic [PHYS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_vld,
  output logic [LINE_W-1:0]     pline,
  output logic                  push,
  input  logic                  full,
  input  logic [LINE_W-1:0]     rline,
  input  logic                  rline_vld,
`ifdef UNCACHED_LABEL_CHECK_EN
  output logic                  resp_err,
`endif
  output logic                  idle
);

  localparam int unsigned TypeBit = LINE_W - 1;
  localparam int unsigned LabelLo = DATA_WIDTH;
  localparam int unsigned BeLo    = DATA_WIDTH + LABEL_W;

  typedef enum logic [1:0] {
    StIdle,
    StWaitResp,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    can_push;
  logic                    push_raw;
  logic                    stall_raw;
  logic                    dec;
  logic [LABEL_W-1:0]      req_label;
  logic                    rline_is_load;

  assign req_label     = req_addr[PHYS_WIDTH-1:OFF_W];
  assign rline_is_load = rline[TypeBit];

  // Loads always request the full word and carry no data.
  always_comb begin
    if (req_we) begin
      pline = {1'b0, req_be, req_label, req_wdata};
    end else begin
      pline = {1'b1, {BE_W{1'b1}}, req_label, {DATA_WIDTH{1'b0}}};
    end
  end

  assign can_push = ~full && (inflight_q < CNT_WIDTH'(MAX_INFLIGHT));

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    push_raw  = 1'b0;
    stall_raw = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          push_raw = can_push;
          if (req_we) begin
            stall_raw = ~can_push;
          end else begin
            stall_raw = 1'b1;
            if (can_push) begin
              state_d = StWaitResp;
            end
          end
        end
      end
      StWaitResp: begin
        stall_raw = 1'b1;
        // Store completions only retire counter entries; only a load line ends the wait.
        if (rline_vld && rline_is_load) begin
          rdata_d = rline[DATA_WIDTH-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // During reset the pipeline is held and nothing may reach the FIFO.
  assign push      = rst & push_raw;
  assign req_stall = ~rst | stall_raw;
  assign rdata     = rdata_q;
  assign rdata_vld = (state_q == StDone);
  assign idle      = (inflight_q == '0) && (state_q == StIdle);

  // A stray completion with nothing in flight saturates at zero.
  assign dec = rline_vld && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    unique case ({push, dec})
      2'b10:   inflight_d = inflight_q + CNT_WIDTH'(1);
      2'b01:   inflight_d = inflight_q - CNT_WIDTH'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      inflight_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      rdata_q    <= rdata_d;
    end
  end

  underflow_chk: assert property (@(posedge clk) disable iff (!rst)
    !(rline_vld && (inflight_q == '0)));

`ifdef UNCACHED_LABEL_CHECK_EN
  logic [LABEL_W-1:0] pend_label_q;
  logic               resp_err_q;
  logic               load_push;
  logic               label_bad;
  logic               unused_bits;

  assign load_push = (state_q == StIdle) && req_valid && !req_we && push;
  assign label_bad = (state_q == StWaitResp) && rline_vld && rline_is_load &&
                     (rline[LabelLo +: LABEL_W] != pend_label_q);

  // The error register lines up with the StDone cycle that delivers the data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_label_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (load_push) begin
        pend_label_q <= req_label;
      end
      resp_err_q <= label_bad;
    end
  end

  assign resp_err    = resp_err_q;
  assign unused_bits = ^{rline[BeLo +: BE_W], req_addr[OFF_W-1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{rline[BeLo +: BE_W], rline[LabelLo +: LABEL_W], req_addr[OFF_W-1:0]};
`endif

endmodule
